dm_sba_ahb_master: RTL and testbench



---
 rtl/dm_sba_ahb_master_if.sv | 42 ++++
 rtl/dm_sba_ahb_master.sv | 148 ++++++++++++++
 tb/tb_dm_sba_ahb_master.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_sba_ahb_master_if.sv
// Bundles the debug-module system-bus-access request channel and the AHB-Lite
// master port; "master" is the bridge's view, "slave" the requester/fabric view.
interface dm_sba_ahb_master_if #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
);
    logic                  sba_req_i;
    logic [HADDR_SIZE-1:0] sba_addr_i;
    logic                  sba_we_i;
    logic [3:0]            sba_be_i;
    logic [HDATA_SIZE-1:0] sba_wdata_i;
    logic                  sba_gnt_o;
    logic                  sba_rvalid_o;
    logic [HDATA_SIZE-1:0] sba_rdata_o;
    logic                  sba_err_o;

    logic [HADDR_SIZE-1:0] HADDR;
    logic [HDATA_SIZE-1:0] HWDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HMASTLOCK;
    logic [HDATA_SIZE-1:0] HRDATA;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        input  sba_req_i, sba_addr_i, sba_we_i, sba_be_i, sba_wdata_i,
        output sba_gnt_o, sba_rvalid_o, sba_rdata_o, sba_err_o,
        output HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        output sba_req_i, sba_addr_i, sba_we_i, sba_be_i, sba_wdata_i,
        input  sba_gnt_o, sba_rvalid_o, sba_rdata_o, sba_err_o,
        input  HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/dm_sba_ahb_master.sv
// Debug-module system-bus-access to AHB-Lite bridge: single non-pipelined
// transfers, one outstanding access, byte enables mapped onto HSIZE/HADDR[1:0].
module dm_sba_ahb_master #(
    parameter int         HADDR_SIZE = 32,
    parameter int         HDATA_SIZE = 32,
    parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    dm_sba_ahb_master_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DATA  = 2'd2,
        ST_BADBE = 2'd3
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Returns {valid, hsize[2:0], offset[1:0]} for a byte-enable pattern.
    function automatic logic [5:0] be_decode(input logic [3:0] be);
        logic [5:0] res;
        case (be)
            4'b1111: res = {1'b1, 3'd2, 2'd0};
            4'b0011: res = {1'b1, 3'd1, 2'd0};
            4'b1100: res = {1'b1, 3'd1, 2'd2};
            4'b0001: res = {1'b1, 3'd0, 2'd0};
            4'b0010: res = {1'b1, 3'd0, 2'd1};
            4'b0100: res = {1'b1, 3'd0, 2'd2};
            4'b1000: res = {1'b1, 3'd0, 2'd3};
            default: res = {1'b0, 3'd0, 2'd0};
        endcase
        return res;
    endfunction

    state_t                r_state;
    logic [1:0]            r_htrans;
    logic [HADDR_SIZE-1:0] r_haddr;
    logic [HDATA_SIZE-1:0] r_hwdata;
    logic [HDATA_SIZE-1:0] r_wdata;
    logic                  r_hwrite;
    logic [2:0]            r_hsize;
    logic                  r_rvalid;
    logic                  r_err;
    logic [HDATA_SIZE-1:0] r_rdata;

    logic                  w_gnt;
    logic [5:0]            w_dec;
    logic                  w_be_ok;
    logic [2:0]            w_size;
    logic [1:0]            w_off;
    logic                  w_unused_addr_lsb;

    assign w_gnt   = bus.sba_req_i && (r_state == ST_IDLE);
    assign w_dec   = be_decode(bus.sba_be_i);
    assign w_be_ok = w_dec[5];
    assign w_size  = w_dec[4:2];
    assign w_off   = w_dec[1:0];
    // Requester address is word aligned; the low bits come from the byte enables.
    assign w_unused_addr_lsb = ^bus.sba_addr_i[1:0];

    // Request acceptance, address/data phase sequencing and response capture.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state  <= ST_IDLE;
            r_htrans <= HTRANS_IDLE;
            r_haddr  <= {HADDR_SIZE{1'b0}};
            r_hwdata <= {HDATA_SIZE{1'b0}};
            r_wdata  <= {HDATA_SIZE{1'b0}};
            r_hwrite <= 1'b0;
            r_hsize  <= 3'd0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= {HDATA_SIZE{1'b0}};
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt) begin
                        if (w_be_ok) begin
                            r_state  <= ST_ADDR;
                            r_htrans <= HTRANS_NONSEQ;
                            r_haddr  <= {bus.sba_addr_i[HADDR_SIZE-1:2], w_off};
                            r_hwrite <= bus.sba_we_i;
                            r_hsize  <= w_size;
                            r_wdata  <= bus.sba_wdata_i;
                        end else begin
                            // Illegal lane pattern: answer with an error, never touch the bus.
                            r_state  <= ST_BADBE;
                            r_rvalid <= 1'b1;
                            r_err    <= 1'b1;
                            r_rdata  <= {HDATA_SIZE{1'b0}};
                        end
                    end
                end
                ST_ADDR: begin
                    if (bus.HREADY) begin
                        r_state  <= ST_DATA;
                        r_htrans <= HTRANS_IDLE;
                        if (r_hwrite) begin
                            r_hwdata <= r_wdata;
                        end
                    end
                end
                ST_DATA: begin
                    if (bus.HREADY) begin
                        r_state  <= ST_IDLE;
                        r_rvalid <= 1'b1;
                        if (bus.HRESP) begin
                            r_err   <= 1'b1;
                            r_rdata <= {HDATA_SIZE{1'b0}};
                        end else begin
                            r_err <= 1'b0;
                            if (!r_hwrite) begin
                                r_rdata <= bus.HRDATA;
                            end
                        end
                    end
                end
                ST_BADBE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_htrans <= HTRANS_IDLE;
                end
            endcase
        end
    end

    assign bus.sba_gnt_o    = w_gnt;
    assign bus.sba_rvalid_o = r_rvalid;
    assign bus.sba_err_o    = r_err;
    assign bus.sba_rdata_o  = r_rdata;

    assign bus.HTRANS    = r_htrans;
    assign bus.HADDR     = r_haddr;
    assign bus.HWDATA    = r_hwdata;
    assign bus.HWRITE    = r_hwrite;
    assign bus.HSIZE     = r_hsize;
    assign bus.HBURST    = 3'b000;
    assign bus.HPROT     = HPROT_VAL;
    assign bus.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_dm_sba_ahb_master.sv
// Self-checking bench for dm_sba_ahb_master: scoreboard of expected address
// phases, write data and responses against a small AHB slave model.
module tb_dm_sba_ahb_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dm_sba_ahb_master_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus ();

    dm_sba_ahb_master #(
        .HADDR_SIZE(32),
        .HDATA_SIZE(32),
        .HPROT_VAL (4'b0011)
    ) dut (
        .HCLK  (clk),
        .HRESET(rst),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        write;
    } aphase_t;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        logic        chk_rdata;
    } resp_t;

    int n_cmp = 0;
    int n_err = 0;

    aphase_t     exp_aq[$];
    aphase_t     obs_aq[$];
    resp_t       exp_rq[$];
    logic [31:0] exp_wq[$];
    logic [31:0] obs_wq[$];

    int          cfg_wait  = 0;
    bit          cfg_err   = 1'b0;
    logic [31:0] cfg_rdata = 32'h0;

    // AHB slave model: decides HREADY/HRESP for the current cycle at each negedge.
    initial begin
        bit   in_data;
        int   wcnt;
        logic rdy;
        in_data    = 1'b0;
        wcnt       = 0;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_data    = 1'b0;
                wcnt       = 0;
                bus.HREADY = 1'b1;
                bus.HRESP  = 1'b0;
            end else if (in_data) begin
                if (cfg_err) begin
                    bus.HRESP = 1'b1;
                    rdy = (wcnt >= 1);
                end else begin
                    bus.HRESP = 1'b0;
                    rdy = (wcnt >= cfg_wait);
                end
                bus.HREADY = rdy;
                bus.HRDATA = rdy ? cfg_rdata : 32'h0;
                wcnt++;
                if (rdy) begin
                    if (bus.HWRITE) obs_wq.push_back(bus.HWDATA);
                    in_data = 1'b0;
                    wcnt    = 0;
                end
            end else begin
                bus.HREADY = 1'b1;
                bus.HRESP  = 1'b0;
                if (bus.HTRANS == 2'b10) begin
                    obs_aq.push_back(aphase_t'({bus.HADDR, bus.HSIZE, bus.HWRITE}));
                    in_data = 1'b1;
                    wcnt    = 0;
                end
            end
        end
    end

    // Drives one request and gathers what the bridge returned (cycle 0 = grant).
    task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, output int g_wait, output int rv_cyc,
                         output logic err, output logic [31:0] rdata, output int n_ns,
                         output bit tmo);
        bit got;
        rv_cyc = -1; n_ns = 0; tmo = 1'b0; err = 1'b0; rdata = 32'h0; g_wait = 0;
        @(negedge clk);
        bus.sba_req_i   = 1'b1;
        bus.sba_addr_i  = a;
        bus.sba_we_i    = we;
        bus.sba_be_i    = be;
        bus.sba_wdata_i = wd;
        #1;
        while (!bus.sba_gnt_o && g_wait < 20) begin
            @(negedge clk); #1;
            g_wait++;
        end
        if (!bus.sba_gnt_o) begin
            tmo = 1'b1;
            bus.sba_req_i = 1'b0;
            return;
        end
        got = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk); #1;
            if (c == 1) bus.sba_req_i = 1'b0;
            if (bus.HTRANS == 2'b10) n_ns++;
            if (bus.sba_rvalid_o) begin
                got    = 1'b1;
                rv_cyc = c;
                err    = bus.sba_err_o;
                rdata  = bus.sba_rdata_o;
            end
        end
        if (!got) tmo = 1'b1;
    endtask

    task automatic test_reset();
        bus.sba_req_i = 1'b0; bus.sba_addr_i = 32'h0; bus.sba_we_i = 1'b0;
        bus.sba_be_i = 4'h0; bus.sba_wdata_i = 32'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (bus.HTRANS !== 2'b00) begin n_err++; $display("FAIL rst_htrans: got %b want 00", bus.HTRANS); end
        n_cmp++; if (bus.HADDR !== 32'h0) begin n_err++; $display("FAIL rst_haddr: got %h want 0", bus.HADDR); end
        n_cmp++; if (bus.HWDATA !== 32'h0) begin n_err++; $display("FAIL rst_hwdata: got %h want 0", bus.HWDATA); end
        n_cmp++; if ({bus.HWRITE, bus.HSIZE} !== 4'h0) begin n_err++; $display("FAIL rst_ctrl: got %b want 0000", {bus.HWRITE, bus.HSIZE}); end
        n_cmp++; if ({bus.sba_rvalid_o, bus.sba_err_o} !== 2'b00) begin n_err++; $display("FAIL rst_rvalid_err: got %b want 00", {bus.sba_rvalid_o, bus.sba_err_o}); end
        n_cmp++; if (bus.sba_rdata_o !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", bus.sba_rdata_o); end
        n_cmp++; if ({bus.HBURST, bus.HPROT, bus.HMASTLOCK} !== {3'b000, 4'b0011, 1'b0}) begin
            n_err++; $display("FAIL rst_consts: got %b want 00000110", {bus.HBURST, bus.HPROT, bus.HMASTLOCK});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Pops and compares the next expected address phase, write data (if any) and response.
    task automatic score(input string nm, input logic we, input logic err, input logic [31:0] rdata);
        aphase_t ea, oa;
        resp_t   er;
        logic [31:0] ew, ow;
        ea = exp_aq.pop_front();
        n_cmp++;
        if (obs_aq.size() == 0) begin n_err++; $display("FAIL %s_aphase: got none want %h", nm, ea); end
        else begin
            oa = obs_aq.pop_front();
            if (oa !== ea) begin n_err++; $display("FAIL %s_aphase: got %h want %h", nm, oa, ea); end
        end
        if (we) begin
            ew = exp_wq.pop_front();
            n_cmp++;
            if (obs_wq.size() == 0) begin n_err++; $display("FAIL %s_hwdata: got none want %h", nm, ew); end
            else begin
                ow = obs_wq.pop_front();
                if (ow !== ew) begin n_err++; $display("FAIL %s_hwdata: got %h want %h", nm, ow, ew); end
            end
        end
        er = exp_rq.pop_front();
        n_cmp++;
        if (err !== er.err) begin n_err++; $display("FAIL %s_err: got %b want %b", nm, err, er.err); end
        if (er.chk_rdata) begin
            n_cmp++;
            if (rdata !== er.rdata) begin n_err++; $display("FAIL %s_rdata: got %h want %h", nm, rdata, er.rdata); end
        end
    endtask

    task automatic test_word_write();
        int gw, rv, ns; logic e; logic [31:0] rd; bit tmo;
        exp_aq.push_back(aphase_t'({32'h2000_0010, 3'd2, 1'b1}));
        exp_wq.push_back(32'hDEAD_BEEF);
        exp_rq.push_back(resp_t'({1'b0, 32'h0, 1'b0}));
        issue(32'h2000_0010, 1'b1, 4'b1111, 32'hDEAD_BEEF, gw, rv, e, rd, ns, tmo);
        n_cmp++; if (tmo || gw != 0 || rv != 3) begin n_err++; $display("FAIL ww_timing: got tmo=%0d gnt_wait=%0d rvalid_cyc=%0d want 0/0/3", tmo, gw, rv); end
        n_cmp++; if (ns != 1) begin n_err++; $display("FAIL ww_nonseq: got %0d want 1", ns); end
        score("ww", 1'b1, e, rd);
        @(negedge clk); #1;
        n_cmp++; if (bus.sba_rvalid_o !== 1'b0) begin n_err++; $display("FAIL ww_pulse: got %b want 0", bus.sba_rvalid_o); end
    endtask

    task automatic test_byte_read_wait();
        int gw, rv, ns; logic e; logic [31:0] rd; bit tmo;
        cfg_wait = 2; cfg_rdata = 32'h00AB_0000;
        exp_aq.push_back(aphase_t'({32'h1000_0006, 3'd0, 1'b0}));
        exp_rq.push_back(resp_t'({1'b0, 32'h00AB_0000, 1'b1}));
        issue(32'h1000_0004, 1'b0, 4'b0100, 32'h0, gw, rv, e, rd, ns, tmo);
        n_cmp++; if (tmo || rv != 5) begin n_err++; $display("FAIL br_timing: got tmo=%0d rvalid_cyc=%0d want 0/5", tmo, rv); end
        score("br", 1'b0, e, rd);
        cfg_wait = 0;
    endtask

    task automatic test_error_resp();
        int gw, rv, ns; logic e; logic [31:0] rd; bit tmo;
        cfg_err = 1'b1; cfg_rdata = 32'h5555_AAAA;
        exp_aq.push_back(aphase_t'({32'h3000_000A, 3'd1, 1'b0}));
        exp_rq.push_back(resp_t'({1'b1, 32'h0, 1'b1}));
        issue(32'h3000_0008, 1'b0, 4'b1100, 32'h0, gw, rv, e, rd, ns, tmo);
        n_cmp++; if (tmo || gw != 0 || rv != 4) begin n_err++; $display("FAIL er_timing: got tmo=%0d gnt_wait=%0d rvalid_cyc=%0d want 0/0/4", tmo, gw, rv); end
        score("er", 1'b0, e, rd);
        cfg_err = 1'b0;
    endtask

    task automatic test_bad_be();
        logic [3:0] bes [3] = '{4'b0101, 4'b0000, 4'b1110};
        int gw, rv, ns; logic e; logic [31:0] rd; bit tmo;
        for (int i = 0; i < 3; i++) begin
            issue(32'h7000_0000, 1'b0, bes[i], 32'h0, gw, rv, e, rd, ns, tmo);
            n_cmp++; if (tmo || gw != 0 || rv != 1) begin n_err++; $display("FAIL bad_be_timing[%b]: got tmo=%0d gnt_wait=%0d rvalid_cyc=%0d want 0/0/1", bes[i], tmo, gw, rv); end
            n_cmp++; if (e !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL bad_be_resp[%b]: got err=%b rdata=%h want 1/0", bes[i], e, rd); end
            repeat (2) @(negedge clk);
            n_cmp++; if (ns != 0 || obs_aq.size() != 0) begin n_err++; $display("FAIL bad_be_bus[%b]: got nonseq=%0d aphases=%0d want 0/0", bes[i], ns, obs_aq.size()); end
        end
    endtask

    task automatic test_be_decode();
        logic [3:0] bes  [4] = '{4'b0011, 4'b1000, 4'b0001, 4'b0010};
        logic [1:0] offs [4] = '{2'd0, 2'd3, 2'd0, 2'd1};
        logic [2:0] szs  [4] = '{3'd1, 3'd0, 3'd0, 3'd0};
        int gw, rv, ns; logic e; logic [31:0] rd; bit tmo;
        logic [31:0] base, dat;
        for (int i = 0; i < 4; i++) begin
            base = 32'h6000_0000 + 32'(i) * 32'h10;
            dat  = $urandom;
            cfg_rdata = dat;
            exp_aq.push_back(aphase_t'({base[31:2], offs[i], szs[i], 1'b0}));
            exp_rq.push_back(resp_t'({1'b0, dat, 1'b1}));
            issue(base, 1'b0, bes[i], 32'h0, gw, rv, e, rd, ns, tmo);
            n_cmp++; if (tmo || rv != 3) begin n_err++; $display("FAIL dec_timing[%b]: got tmo=%0d rvalid_cyc=%0d want 0/3", bes[i], tmo, rv); end
            score("dec", 1'b0, e, rd);
        end
    endtask

    task automatic test_back_to_back();
        int g[2], r[2];
        int ng, nr, ns;
        bit sw;
        resp_t er;
        exp_aq.push_back(aphase_t'({32'h4000_0000, 3'd2, 1'b1}));
        exp_wq.push_back(32'h1122_3344);
        exp_rq.push_back(resp_t'({1'b0, 32'h0, 1'b0}));
        exp_aq.push_back(aphase_t'({32'h4000_0004, 3'd1, 1'b0}));
        exp_rq.push_back(resp_t'({1'b0, 32'hCAFE_F00D, 1'b1}));
        cfg_rdata = 32'hCAFE_F00D;
        g[0] = -1; g[1] = -1; r[0] = -1; r[1] = -1;
        ng = 0; nr = 0; ns = 0; sw = 1'b0;
        @(negedge clk);
        bus.sba_req_i = 1'b1; bus.sba_addr_i = 32'h4000_0000; bus.sba_we_i = 1'b1;
        bus.sba_be_i = 4'b1111; bus.sba_wdata_i = 32'h1122_3344;
        #1;
        for (int c = 0; c < 30 && nr < 2; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            if (ng >= 2) bus.sba_req_i = 1'b0;
            if (ng == 1 && !sw) begin
                bus.sba_addr_i = 32'h4000_0004; bus.sba_we_i = 1'b0;
                bus.sba_be_i = 4'b0011; bus.sba_wdata_i = 32'h0;
                sw = 1'b1; #1;
            end
            if (bus.HTRANS == 2'b10) ns++;
            if (bus.sba_rvalid_o) begin
                if (nr < 2) r[nr] = c;
                n_cmp++;
                if (exp_rq.size() == 0) begin n_err++; $display("FAIL b2b_resp: got extra rvalid want none"); end
                else begin
                    er = exp_rq.pop_front();
                    if (bus.sba_err_o !== er.err || (er.chk_rdata && bus.sba_rdata_o !== er.rdata)) begin
                        n_err++; $display("FAIL b2b_resp%0d: got err=%b rdata=%h want err=%b rdata=%h", nr, bus.sba_err_o, bus.sba_rdata_o, er.err, er.rdata);
                    end
                end
                nr++;
            end
            if (bus.sba_gnt_o) begin
                if (ng < 2) g[ng] = c;
                ng++;
            end
        end
        bus.sba_req_i = 1'b0;
        n_cmp++; if (ng != 2 || nr != 2) begin n_err++; $display("FAIL b2b_counts: got gnt=%0d rvalid=%0d want 2/2", ng, nr); end
        n_cmp++; if (g[1] != r[0] || r[0] != 3 || r[1] != 6) begin n_err++; $display("FAIL b2b_overlap: got gnt2=%0d rv1=%0d rv2=%0d want 3/3/6", g[1], r[0], r[1]); end
        n_cmp++; if (ns != 2) begin n_err++; $display("FAIL b2b_nonseq: got %0d want 2", ns); end
        for (int k = 0; k < 2; k++) begin
            aphase_t ea, oa;
            ea = exp_aq.pop_front();
            n_cmp++;
            if (obs_aq.size() == 0) begin n_err++; $display("FAIL b2b_aphase%0d: got none want %h", k, ea); end
            else begin
                oa = obs_aq.pop_front();
                if (oa !== ea) begin n_err++; $display("FAIL b2b_aphase%0d: got %h want %h", k, oa, ea); end
            end
        end
        n_cmp++;
        if (obs_wq.size() != 1 || obs_wq[0] !== exp_wq[0]) begin
            n_err++; $display("FAIL b2b_hwdata: got %0d words want 1 word %h", obs_wq.size(), exp_wq[0]);
        end
        obs_wq.delete(); exp_wq.delete();
        @(negedge clk); #1;
        n_cmp++; if (bus.sba_rvalid_o !== 1'b0) begin n_err++; $display("FAIL b2b_extra: got rvalid %b want 0", bus.sba_rvalid_o); end
    endtask

    task automatic test_reset_mid();
        int gw, rv, ns, nrv; logic e; logic [31:0] rd; bit tmo;
        cfg_wait = 5;
        @(negedge clk);
        bus.sba_req_i = 1'b1; bus.sba_addr_i = 32'h5000_0000; bus.sba_we_i = 1'b0;
        bus.sba_be_i = 4'b1111; bus.sba_wdata_i = 32'h0;
        #1;
        n_cmp++; if (bus.sba_gnt_o !== 1'b1) begin n_err++; $display("FAIL rm_gnt: got %b want 1", bus.sba_gnt_o); end
        @(negedge clk); bus.sba_req_i = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (bus.HTRANS !== 2'b00 || bus.sba_rvalid_o !== 1'b0 || bus.HADDR !== 32'h0) begin
            n_err++; $display("FAIL rm_after_rst: got htrans=%b rvalid=%b haddr=%h want 00/0/0", bus.HTRANS, bus.sba_rvalid_o, bus.HADDR);
        end
        @(negedge clk); rst = 1'b0; cfg_wait = 0;
        nrv = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            if (bus.sba_rvalid_o) nrv++;
        end
        n_cmp++; if (nrv != 0) begin n_err++; $display("FAIL rm_no_rvalid: got %0d rvalids want 0", nrv); end
        obs_aq.delete(); obs_wq.delete();
        cfg_rdata = 32'h0BAD_F00D;
        exp_aq.push_back(aphase_t'({32'h5000_0020, 3'd2, 1'b0}));
        exp_rq.push_back(resp_t'({1'b0, 32'h0BAD_F00D, 1'b1}));
        issue(32'h5000_0020, 1'b0, 4'b1111, 32'h0, gw, rv, e, rd, ns, tmo);
        n_cmp++; if (tmo || gw != 0 || rv != 3) begin n_err++; $display("FAIL rm_next: got tmo=%0d gnt_wait=%0d rvalid_cyc=%0d want 0/0/3", tmo, gw, rv); end
        score("rm", 1'b0, e, rd);
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_byte_read_wait();
        test_error_resp();
        test_bad_be();
        test_be_decode();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
